int_ctrl_n: RTL and testbench
=============================

Name: int_ctrl_n

Overview:
Parametrised, vectored, nesting interrupt controller for the single-cycle pP core. It replaces the single-request, single-level interrupt register.
- Arbitrates NCH request lines by fixed priority.
- Supplies a per-channel vector address to the next-address mux.
- Saves return PC and condition codes on an internal context stack of DEPTH entries.
- Restores them on return-from-interrupt.

Parameters:
NCH, 4, number of interrupt channels; channel 0 has the highest priority.
AW, 12, PC / address width.
DEPTH, 4, maximum nesting depth (number of context-stack entries), at least 1.
VEC_BASE, 12'h004, vector address of channel 0.
VEC_STRIDE, 4, address distance between consecutive channel vectors.

Ports:
ck  in  1  clock, rising edge.
res  in  1  synchronous reset, active-low.
irq  in  NCH  interrupt requests.
stall  in  1  core is not at an instruction boundary; blocks take.
ie_set  in  1  EI executed this cycle.
ie_clr  in  1  DI executed this cycle.
mask_wr  in  1  load mask register.
mask_d  in  NCH  new mask value; 1 = channel enabled.
ret_i  in  1  RETI executed this cycle.
one_addr  in  AW  PC+1 of the current instruction (return address).
cc_z  in  1  current Z flag.
cc_c  in  1  current C flag.
take  out  1  comb: next_addr must select vec_addr this cycle.
vec_addr  out  AW  comb: vector of the winning channel.
ret_pc  out  AW  comb: PC field of the top context-stack entry.
ret_z  out  1  comb: Z field of the top entry.
ret_c  out  1  comb: C field of the top entry.
int_en  out  1  global interrupt enable (registered).
int_ack  out  NCH  registered one-hot acknowledge pulse.
level  out  clog2(NCH+1)  active priority level; NCH = none active.
depth  out  clog2(DEPTH+1)  current nesting depth.
err  out  1  sticky flag: RETI issued with depth 0.

Behaviour:
Reset (res=0 at a rising edge):
- int_en=0, mask=0, int_ack=0, level=NCH, depth=0, err=0.
- Pending latches cleared (EDGE_DET_EN builds only).
- Context-stack contents are don't-care.
- Reset mid-nest discards all saved contexts.

Arbitration (combinational):
- cand = src & mask, where src = irq (level build) or pend (edge build).
- win = lowest set index of cand.
- take = int_en & |cand & (win < level) & (depth < DEPTH) & !stall & !ret_i.
- vec_addr = VEC_BASE + win*VEC_STRIDE, truncated to AW. Value is don't-care when take=0.

On an edge where take=1:
- Push {one_addr, cc_z, cc_c, level} onto the stack.
- depth += 1; level := win; int_en := 0.
- int_ack := one-hot(win) for exactly the next cycle, 0 otherwise.

On an edge where ret_i=1 and depth>0:
- Pop the stack; level := saved level; depth -= 1; int_en := 1.
- The core uses ret_pc/ret_z/ret_c during the RETI cycle. These outputs always reflect the top entry.

RETI with depth=0:
- No state change except err := 1.
- ret_* outputs are don't-care.

Priority and nesting rules:
- Equal or lower priority than the active level never preempts; the request stays pending.
- depth == DEPTH blocks all takes; no overflow is possible.
- ret_i and a candidate in the same cycle: return wins; take is suppressed and may fire in the following cycle.

Control and mask:
- ie_clr and ie_set together: clear wins.
- A take on the same edge as ie_set leaves int_en=0.
- mask_wr: mask := mask_d at the edge; the new mask takes effect from the next cycle.

Optional Feature:
Macro INT_EDGE_DET_EN.
- Defined:
  - Per-channel pend latch, set by a rising edge of irq (irq & ~irq_q, where irq_q is a registered copy).
  - Latching is independent of mask.
  - The bit is cleared on the take of that channel.
  - A set and a clear in the same cycle: set wins.
  - src = pend.
- Undefined:
  - Level-sensitive; src = irq.
  - The device holds irq until serviced.
  - No pend or irq_q registers are built.

Test Plan:
1. Reset, EI, mask=4'b1111; irq=4'b0100 with one_addr=0x123, Z=1, C=0.
   -> take=1, vec_addr=0x00C.
   -> Next cycle: int_ack=4'b0100, level=2, depth=1, int_en=0.
   -> RETI: ret_pc=0x123, ret_z=1, ret_c=0; then depth=0, level=4, int_en=1.
2. Nesting: in ch2 handler, EI; irq[0] asserted.
   -> take with vec_addr=0x004, depth=2.
   -> irq[3] during the ch0 handler is ignored until both RETIs complete.
3. DEPTH=2 full; EI with irq[0] active.
   -> take stays 0 until one RETI.
4. Same cycle: ret_i=1 and irq[1] (int_en=1).
   -> take=0; pop occurs.
   -> Next cycle: take=1 to 0x008.
5. RETI at depth 0.
   -> err=1, depth stays 0.
   -> Then res=0 for one edge: err=0, mask=0, int_en=0.
6. INT_EDGE_DET_EN: 1-cycle irq[1] pulse while int_en=0.
   -> pend held.
   -> After EI: take to 0x008, pend[1] cleared, no second take.

Source files
------------

// File: rtl/int_ctrl_n.sv
// int_ctrl_n: vectored, nesting, fixed-priority interrupt controller for the
// single-cycle pP core. Channel 0 has the highest priority. Each take pushes
// the return PC, the condition codes and the preempted level onto a small
// context stack, and RETI pops them again.
// Optional feature macro: INT_EDGE_DET_EN. When it is defined, requests are
// rising-edge latched into per-channel pend bits. When it is undefined,
// requests are level-sensitive.
module int_ctrl_n #(
   parameter int NCH = 4,
   parameter int AW = 12,
   parameter int DEPTH = 4,
   parameter logic [AW-1:0] VEC_BASE = AW'(12'h004),
   parameter int VEC_STRIDE = 4,
   localparam int LW = $clog2(NCH + 1),
   localparam int DW = $clog2(DEPTH + 1)
) (
   input  logic          ck,
   input  logic          res,
   input  logic [NCH-1:0] irq,
   input  logic          stall,
   input  logic          ie_set,
   input  logic          ie_clr,
   input  logic          mask_wr,
   input  logic [NCH-1:0] mask_d,
   input  logic          ret_i,
   input  logic [AW-1:0] one_addr,
   input  logic          cc_z,
   input  logic          cc_c,
   output logic          take,
   output logic [AW-1:0] vec_addr,
   output logic [AW-1:0] ret_pc,
   output logic          ret_z,
   output logic          ret_c,
   output logic          int_en,
   output logic [NCH-1:0] int_ack,
   output logic [LW-1:0] level,
   output logic [DW-1:0] depth,
   output logic          err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NCH-1:0] mask;
   logic [NCH-1:0] src;
   logic [NCH-1:0] cand;
   logic [LW-1:0]  win;
   logic [NCH-1:0] win_onehot;
   logic           pop;
   logic [PW-1:0]  top_idx;
   logic [PW-1:0]  push_idx;

   logic [AW-1:0]  stk_pc  [DEPTH];
   logic           stk_z   [DEPTH];
   logic           stk_c   [DEPTH];
   logic [LW-1:0]  stk_lvl [DEPTH];

`ifdef INT_EDGE_DET_EN
   logic [NCH-1:0] pend;
   logic [NCH-1:0] irq_q;

   // A rising edge of irq latches a pend bit. Latching ignores the mask. A
   // take clears the bit of the winning channel, but a new edge in the same
   // cycle sets it again.
   always_ff @(posedge ck) begin
      if (!res) begin
         pend  <= '0;
         irq_q <= '0;
      end else begin
         irq_q <= irq;
         pend  <= (pend & ~(take ? win_onehot : '0)) | (irq & ~irq_q);
      end
   end

   // Arbitration source: latched edges.
   always_comb src = pend;
`else
   // Arbitration source: raw request levels, held by the device until serviced.
   always_comb src = irq;
`endif

   // Pick the lowest-numbered enabled request. A result of NCH means none.
   always_comb begin
      cand = src & mask;
      win  = LW'(NCH);
      for (int i = NCH - 1; i >= 0; i--) begin
         if (cand[i]) win = LW'(i);
      end
   end

   // Decide whether to take and form the vector. RETI suppresses a take in
   // the same cycle, so the return always completes first.
   always_comb begin
      win_onehot = NCH'(1) << win;
      take       = int_en & (|cand) & (win < level) & (depth < DW'(DEPTH))
                   & ~stall & ~ret_i;
      vec_addr   = VEC_BASE + AW'(VEC_STRIDE) * AW'(win);
      pop        = ret_i & (depth != '0);
      top_idx    = (depth == '0) ? '0 : PW'(depth - DW'(1));
      push_idx   = PW'(depth);
      ret_pc     = stk_pc[top_idx];
      ret_z      = stk_z[top_idx];
      ret_c      = stk_c[top_idx];
   end

   // Context stack storage. It has no reset because entries above depth are
   // never read.
   always_ff @(posedge ck) begin
      if (take) begin
         stk_pc[push_idx]  <= one_addr;
         stk_z[push_idx]   <= cc_z;
         stk_c[push_idx]   <= cc_c;
         stk_lvl[push_idx] <= level;
      end
   end

   // Control state: enable, mask, active level, nesting depth, ack and error.
   always_ff @(posedge ck) begin
      if (!res) begin
         int_en  <= 1'b0;
         mask    <= '0;
         int_ack <= '0;
         level   <= LW'(NCH);
         depth   <= '0;
         err     <= 1'b0;
      end else begin
         int_ack <= take ? win_onehot : '0;
         if (mask_wr) mask <= mask_d;
         if (take) begin
            depth  <= depth + DW'(1);
            level  <= win;
            int_en <= 1'b0;
         end else if (pop) begin
            depth  <= depth - DW'(1);
            level  <= stk_lvl[top_idx];
            int_en <= 1'b1;
         end else if (ie_clr) begin
            int_en <= 1'b0;
         end else if (ie_set) begin
            int_en <= 1'b1;
         end
         if (ret_i && depth == '0) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_int_ctrl_n.sv
// tb_int_ctrl_n: directed, self-checking bench for int_ctrl_n. The DUT is
// built with DEPTH=2 so that a full context stack is easy to reach.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// before the next rising edge.
module tb_int_ctrl_n;

   logic        ck, res, stall, ie_set, ie_clr, mask_wr, ret_i, cc_z, cc_c;
   logic [3:0]  irq, mask_d;
   logic [11:0] one_addr;
   logic        take, ret_z, ret_c, int_en, err;
   logic [11:0] vec_addr, ret_pc;
   logic [3:0]  int_ack;
   logic [2:0]  level;
   logic [1:0]  depth;

   int tests;
   int fails;

   int_ctrl_n #(.NCH(4), .AW(12), .DEPTH(2), .VEC_BASE(12'h004), .VEC_STRIDE(4)) dut (
      .ck(ck), .res(res), .irq(irq), .stall(stall), .ie_set(ie_set), .ie_clr(ie_clr),
      .mask_wr(mask_wr), .mask_d(mask_d), .ret_i(ret_i), .one_addr(one_addr),
      .cc_z(cc_z), .cc_c(cc_c), .take(take), .vec_addr(vec_addr), .ret_pc(ret_pc),
      .ret_z(ret_z), .ret_c(ret_c), .int_en(int_en), .int_ack(int_ack),
      .level(level), .depth(depth), .err(err)
   );

   // Free-running clock with a period of 10.
   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   // In the edge-detect build, a new request needs one edge to reach pend.
   task automatic latch_wait();
`ifdef INT_EDGE_DET_EN
      step();
`endif
   endtask

   task automatic test_reset();
      res = 1'b0; step(); res = 1'b1; #1;
      tests++; if (int_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_int_en: got %0b want 0", int_en); end
      tests++; if (level !== 3'd4) begin fails++; $display("[TB] FAIL reset_level: got %0d want 4", level); end
      tests++; if (depth !== 2'd0) begin fails++; $display("[TB] FAIL reset_depth: got %0d want 0", depth); end
      tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %0b want 0", err); end
      tests++; if (int_ack !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ack: got %b want 0000", int_ack); end
   endtask

   task automatic test_basic();
      ie_set = 1'b1; mask_wr = 1'b1; mask_d = 4'b1111; step();
      ie_set = 1'b0; mask_wr = 1'b0;
      irq = 4'b0100; one_addr = 12'h123; cc_z = 1'b1; cc_c = 1'b0;
      latch_wait(); #1;
      tests++; if (take !== 1'b1) begin fails++; $display("[TB] FAIL basic_take: got %0b want 1", take); end
      tests++; if (vec_addr !== 12'h00C) begin fails++; $display("[TB] FAIL basic_vec: got %h want 00c", vec_addr); end
      step(); irq = 4'b0000; #1;
      tests++; if (int_ack !== 4'b0100) begin fails++; $display("[TB] FAIL basic_ack: got %b want 0100", int_ack); end
      tests++; if (level !== 3'd2) begin fails++; $display("[TB] FAIL basic_level: got %0d want 2", level); end
      tests++; if (depth !== 2'd1) begin fails++; $display("[TB] FAIL basic_depth: got %0d want 1", depth); end
      tests++; if (int_en !== 1'b0) begin fails++; $display("[TB] FAIL basic_int_en: got %0b want 0", int_en); end
      step();
      tests++; if (int_ack !== 4'b0000) begin fails++; $display("[TB] FAIL basic_ack_pulse: got %b want 0000", int_ack); end
      ret_i = 1'b1; #1;
      tests++; if (ret_pc !== 12'h123) begin fails++; $display("[TB] FAIL basic_ret_pc: got %h want 123", ret_pc); end
      tests++; if (ret_z !== 1'b1 || ret_c !== 1'b0) begin fails++; $display("[TB] FAIL basic_ret_cc: got z=%0b c=%0b want z=1 c=0", ret_z, ret_c); end
      step(); ret_i = 1'b0; #1;
      tests++; if (depth !== 2'd0 || level !== 3'd4 || int_en !== 1'b1) begin fails++; $display("[TB] FAIL basic_after_reti: got d=%0d l=%0d en=%0b want d=0 l=4 en=1", depth, level, int_en); end
   endtask

   task automatic test_nesting();
      irq = 4'b0100; one_addr = 12'h200; cc_z = 1'b0; cc_c = 1'b0;
      latch_wait(); step(); irq = 4'b0000;
      ie_set = 1'b1; step(); ie_set = 1'b0;
      irq = 4'b0001; one_addr = 12'h210; cc_c = 1'b1;
      latch_wait(); #1;
      tests++; if (take !== 1'b1 || vec_addr !== 12'h004) begin fails++; $display("[TB] FAIL nest_take: got take=%0b vec=%h want take=1 vec=004", take, vec_addr); end
      step(); irq = 4'b1000; #1;
      tests++; if (depth !== 2'd2 || level !== 3'd0) begin fails++; $display("[TB] FAIL nest_depth: got d=%0d l=%0d want d=2 l=0", depth, level); end
      ie_set = 1'b1; step(); ie_set = 1'b0; latch_wait(); #1;
      tests++; if (take !== 1'b0) begin fails++; $display("[TB] FAIL nest_low_blocked: got %0b want 0", take); end
      ret_i = 1'b1; #1;
      tests++; if (ret_pc !== 12'h210 || ret_c !== 1'b1) begin fails++; $display("[TB] FAIL nest_ret_top: got pc=%h c=%0b want pc=210 c=1", ret_pc, ret_c); end
      step(); ret_i = 1'b0; #1;
      tests++; if (level !== 3'd2 || take !== 1'b0) begin fails++; $display("[TB] FAIL nest_mid_level: got l=%0d take=%0b want l=2 take=0", level, take); end
      ret_i = 1'b1; #1;
      tests++; if (ret_pc !== 12'h200) begin fails++; $display("[TB] FAIL nest_ret_second: got %h want 200", ret_pc); end
      step(); ret_i = 1'b0; #1;
      tests++; if (take !== 1'b1 || vec_addr !== 12'h010) begin fails++; $display("[TB] FAIL nest_ch3_after: got take=%0b vec=%h want take=1 vec=010", take, vec_addr); end
      step(); irq = 4'b0000;
      ret_i = 1'b1; step(); ret_i = 1'b0;
   endtask

   task automatic test_depth_full();
      irq = 4'b0100; one_addr = 12'h300;
      latch_wait(); step(); irq = 4'b0000;
      ie_set = 1'b1; step(); ie_set = 1'b0;
      irq = 4'b0010; latch_wait(); step(); irq = 4'b0000; #1;
      tests++; if (depth !== 2'd2) begin fails++; $display("[TB] FAIL full_depth: got %0d want 2", depth); end
      ie_set = 1'b1; step(); ie_set = 1'b0;
      irq = 4'b0001; latch_wait(); #1;
      tests++; if (take !== 1'b0) begin fails++; $display("[TB] FAIL full_blocked: got %0b want 0", take); end
      step();
      tests++; if (take !== 1'b0 || depth !== 2'd2) begin fails++; $display("[TB] FAIL full_still_blocked: got take=%0b d=%0d want take=0 d=2", take, depth); end
      ret_i = 1'b1; step(); ret_i = 1'b0; #1;
      tests++; if (take !== 1'b1 || vec_addr !== 12'h004) begin fails++; $display("[TB] FAIL full_after_reti: got take=%0b vec=%h want take=1 vec=004", take, vec_addr); end
      step(); irq = 4'b0000;
      ret_i = 1'b1; step(); step(); ret_i = 1'b0; #1;
      tests++; if (depth !== 2'd0 || level !== 3'd4) begin fails++; $display("[TB] FAIL full_unwound: got d=%0d l=%0d want d=0 l=4", depth, level); end
   endtask

   task automatic test_ret_vs_take();
      irq = 4'b0100; one_addr = 12'h400;
      latch_wait(); step(); irq = 4'b0000;
      ie_set = 1'b1; step(); ie_set = 1'b0;
      irq = 4'b0010; ret_i = 1'b1; #1;
      tests++; if (take !== 1'b0) begin fails++; $display("[TB] FAIL rvt_suppressed: got %0b want 0", take); end
      step(); ret_i = 1'b0; #1;
      tests++; if (depth !== 2'd0 || level !== 3'd4) begin fails++; $display("[TB] FAIL rvt_popped: got d=%0d l=%0d want d=0 l=4", depth, level); end
      tests++; if (take !== 1'b1 || vec_addr !== 12'h008) begin fails++; $display("[TB] FAIL rvt_take_next: got take=%0b vec=%h want take=1 vec=008", take, vec_addr); end
      step(); irq = 4'b0000; #1;
      tests++; if (int_ack !== 4'b0010 || level !== 3'd1) begin fails++; $display("[TB] FAIL rvt_ack: got ack=%b l=%0d want ack=0010 l=1", int_ack, level); end
      ret_i = 1'b1; step(); ret_i = 1'b0;
   endtask

   task automatic test_reti_empty();
      ret_i = 1'b1; step(); ret_i = 1'b0; #1;
      tests++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL empty_err: got %0b want 1", err); end
      tests++; if (depth !== 2'd0 || level !== 3'd4 || int_en !== 1'b1) begin fails++; $display("[TB] FAIL empty_nochange: got d=%0d l=%0d en=%0b want d=0 l=4 en=1", depth, level, int_en); end
      step();
      tests++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL empty_sticky: got %0b want 1", err); end
      res = 1'b0; step(); res = 1'b1; #1;
      tests++; if (err !== 1'b0 || int_en !== 1'b0) begin fails++; $display("[TB] FAIL empty_reset: got err=%0b en=%0b want err=0 en=0", err, int_en); end
      ie_set = 1'b1; step(); ie_set = 1'b0;
      irq = 4'b0001; latch_wait(); #1;
      tests++; if (take !== 1'b0) begin fails++; $display("[TB] FAIL empty_mask_zero: got %0b want 0", take); end
      mask_wr = 1'b1; mask_d = 4'b0001; #1;
      tests++; if (take !== 1'b0) begin fails++; $display("[TB] FAIL mask_not_yet: got %0b want 0", take); end
      step(); mask_wr = 1'b0; #1;
      tests++; if (take !== 1'b1 || vec_addr !== 12'h004) begin fails++; $display("[TB] FAIL mask_effective: got take=%0b vec=%h want take=1 vec=004", take, vec_addr); end
      step(); irq = 4'b0000;
      ret_i = 1'b1; step(); ret_i = 1'b0;
   endtask

   task automatic test_control();
      ie_set = 1'b1; ie_clr = 1'b1; step(); ie_clr = 1'b0; #1;
      tests++; if (int_en !== 1'b0) begin fails++; $display("[TB] FAIL ctl_clr_wins: got %0b want 0", int_en); end
      mask_wr = 1'b1; mask_d = 4'b1111; step(); ie_set = 1'b0; mask_wr = 1'b0; #1;
      tests++; if (int_en !== 1'b1) begin fails++; $display("[TB] FAIL ctl_set: got %0b want 1", int_en); end
      stall = 1'b1; irq = 4'b0100; one_addr = 12'h500;
      latch_wait(); #1;
      tests++; if (take !== 1'b0) begin fails++; $display("[TB] FAIL ctl_stall: got %0b want 0", take); end
      stall = 1'b0; ie_set = 1'b1; #1;
      tests++; if (take !== 1'b1) begin fails++; $display("[TB] FAIL ctl_unstall: got %0b want 1", take); end
      step(); ie_set = 1'b0; irq = 4'b0000; #1;
      tests++; if (int_en !== 1'b0 || depth !== 2'd1) begin fails++; $display("[TB] FAIL ctl_take_over_set: got en=%0b d=%0d want en=0 d=1", int_en, depth); end
      ret_i = 1'b1; step(); ret_i = 1'b0;
   endtask

`ifdef INT_EDGE_DET_EN
   task automatic test_edge_det();
      ie_clr = 1'b1; step(); ie_clr = 1'b0;
      irq = 4'b0010; step(); irq = 4'b0000; step(); step(); #1;
      tests++; if (take !== 1'b0) begin fails++; $display("[TB] FAIL edge_disabled: got %0b want 0", take); end
      ie_set = 1'b1; step(); ie_set = 1'b0; #1;
      tests++; if (take !== 1'b1 || vec_addr !== 12'h008) begin fails++; $display("[TB] FAIL edge_pend_held: got take=%0b vec=%h want take=1 vec=008", take, vec_addr); end
      step(); ret_i = 1'b1; step(); ret_i = 1'b0; #1;
      tests++; if (take !== 1'b0 || depth !== 2'd0) begin fails++; $display("[TB] FAIL edge_pend_cleared: got take=%0b d=%0d want take=0 d=0", take, depth); end
   endtask
`endif

   initial begin
      tests = 0; fails = 0;
      res = 1'b1; irq = '0; stall = 1'b0; ie_set = 1'b0; ie_clr = 1'b0;
      mask_wr = 1'b0; mask_d = '0; ret_i = 1'b0; one_addr = '0; cc_z = 1'b0; cc_c = 1'b0;
      #2;
      test_reset();
      test_basic();
      test_nesting();
      test_depth_full();
      test_ret_vs_take();
      test_reti_empty();
      test_control();
`ifdef INT_EDGE_DET_EN
      test_edge_det();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
